// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle for the ID-stage hazard controller.
// master: the pipeline stages that supply ID/EXE/MEM control fields.
// slave : the hazard controller that returns stall/flush/halt controls.
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 16
);
    // ID-stage source operand information
    logic [4:0]       id_Rs;
    logic [4:0]       id_Rt;
    logic             id_RsValid;
    logic             id_RtValid;
    logic             id_Halt;

    // EXE-stage producer information
    logic             ex_RegWrite;
    logic [1:0]       ex_FwdStage;
    logic [4:0]       ex_DstReg;

    // MEM-stage branch resolution
    logic             mem_Branch;
    logic             mem_Zero;
    logic             mem_Uncond;

    // Controls back to fetch/decode
    logic             injectNop;
    logic             pc_Stall;
    logic             ifid_Stall;
    logic             branchTaken;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_Rs, id_Rt, id_RsValid, id_RtValid, id_Halt,
        output ex_RegWrite, ex_FwdStage, ex_DstReg,
        output mem_Branch, mem_Zero, mem_Uncond,
        input  injectNop, pc_Stall, ifid_Stall, branchTaken, halted, stall_count
    );

    modport slave (
        input  id_Rs, id_Rt, id_RsValid, id_RtValid, id_Halt,
        input  ex_RegWrite, ex_FwdStage, ex_DstReg,
        input  mem_Branch, mem_Zero, mem_Uncond,
        output injectNop, pc_Stall, ifid_Stall, branchTaken, halted, stall_count
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard and sequencing controller.
// - Load-use: a WB-forwarded producer in EXE matching an ID source stalls
//   fetch/decode for one cycle and turns the ID instruction into a bubble.
// - Taken branches/jumps resolved in MEM request a flush and win over
//   everything else in the same cycle (younger work is on the wrong path).
// - A decoded halt drains EXE/MEM/WB, then freezes the core until reset.
//   A taken branch seen while draining cancels the (wrong-path) halt.
// Stall/flush outputs are combinational from the current state and inputs.
module hazard_ctrl_unit #(
    parameter int         DRAIN_CYCLES  = 3,
    parameter int         CNT_W         = 16,
    parameter logic [1:0] RESULT_FWD_WB = 2'd2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_unit_if.slave  bus
);

    // Drain counter holds DRAIN_CYCLES-1 down to 0.
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [DRAIN_W-1:0] drain_r;
    logic [DRAIN_W-1:0] drain_nxt_s;
    logic [CNT_W-1:0]   stall_count_r;

    logic take_s;
    logic rs_hit_s;
    logic rt_hit_s;
    logic luse_s;
    logic count_inc_s;

    logic inject_nop_s;
    logic pc_stall_s;
    logic ifid_stall_s;
    logic branch_taken_s;
    logic halted_s;

    // Branch taken when MEM holds a branch that resolved taken or an unconditional jump.
    assign take_s = bus.mem_Branch & (bus.mem_Zero | bus.mem_Uncond);

    // Source matches against the EXE destination; r0 is never a real producer.
    assign rs_hit_s = bus.id_RsValid & (bus.id_Rs == bus.ex_DstReg);
    assign rt_hit_s = bus.id_RtValid & (bus.id_Rt == bus.ex_DstReg);

    // Only results that first become available in WB (loads) need a bubble;
    // everything earlier is covered by forwarding.
    assign luse_s = bus.ex_RegWrite
                  & (bus.ex_FwdStage == RESULT_FWD_WB)
                  & (bus.ex_DstReg != 5'd0)
                  & (rs_hit_s | rt_hit_s);

    // Next-state and output decode for the run/drain/halted sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        drain_nxt_s    = drain_r;
        count_inc_s    = 1'b0;
        inject_nop_s   = 1'b0;
        pc_stall_s     = 1'b0;
        ifid_stall_s   = 1'b0;
        branch_taken_s = 1'b0;
        halted_s       = 1'b0;

        case (state_r)
            ST_RUN: begin
                if (take_s) begin
                    // Flush wins; halt/load-use in younger stages are wrong-path.
                    branch_taken_s = 1'b1;
                end else if (bus.id_Halt) begin
                    // Decoder already emits a nop for the halt itself.
                    pc_stall_s   = 1'b1;
                    ifid_stall_s = 1'b1;
                    state_nxt_s  = ST_DRAIN;
                    drain_nxt_s  = DRAIN_LOAD;
                end else if (luse_s) begin
                    // One bubble is enough: next cycle the load is in MEM and
                    // the hazard clears without any held state.
                    inject_nop_s = 1'b1;
                    pc_stall_s   = 1'b1;
                    ifid_stall_s = 1'b1;
                    count_inc_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end

            ST_DRAIN: begin
                inject_nop_s = 1'b1;
                pc_stall_s   = 1'b1;
                ifid_stall_s = 1'b1;
                if (take_s) begin
                    // An older branch ahead of the halt redirects: halt was wrong-path.
                    branch_taken_s = 1'b1;
                    drain_nxt_s    = {DRAIN_W{1'b0}};
                    state_nxt_s    = ST_RUN;
                end else if (drain_r == {DRAIN_W{1'b0}}) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    drain_nxt_s = drain_r - DRAIN_W'(1);
                end
            end

            ST_HALTED: begin
                inject_nop_s = 1'b1;
                pc_stall_s   = 1'b1;
                ifid_stall_s = 1'b1;
                halted_s     = 1'b1;
            end

            default: begin
                // Corrupted state encoding: freeze the core rather than run on.
                inject_nop_s = 1'b1;
                pc_stall_s   = 1'b1;
                ifid_stall_s = 1'b1;
                state_nxt_s  = ST_HALTED;
                drain_nxt_s  = {DRAIN_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and drain counter; reset returns to RUN from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            drain_r <= {DRAIN_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            drain_r <= drain_nxt_s;
        end
    end

    // Saturating count of load-use bubbles issued while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (count_inc_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.injectNop   = inject_nop_s;
    assign bus.pc_Stall    = pc_stall_s;
    assign bus.ifid_Stall  = ifid_stall_s;
    assign bus.branchTaken = branch_taken_s;
    assign bus.halted      = halted_s;
    assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios with random
// register/field choices plus a long random run, all against a cycle model
// written from the behavioural rules (mode flags, drain countdown, saturating count).
module tb_hazard_ctrl_unit;

    localparam int         CNT_W   = 4;
    localparam int         DRAIN   = 3;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl_unit #(
        .DRAIN_CYCLES (DRAIN),
        .CNT_W        (CNT_W),
        .RESULT_FWD_WB(FWD_WB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model state
    bit m_halted;
    int m_drain_left;   // remaining drain cycles, 0 when not draining
    int m_count;

    // Expected outputs: {injectNop, pc_Stall, ifid_Stall, branchTaken, halted}
    logic [4:0]       exp_flags;
    logic [CNT_W-1:0] exp_count;
    logic [4:0]       got_flags;

    function automatic bit m_take();
        return bus.mem_Branch && (bus.mem_Zero || bus.mem_Uncond);
    endfunction

    function automatic bit m_hazard();
        bit src_match;
        src_match = (bus.id_RsValid && bus.id_Rs == bus.ex_DstReg) ||
                    (bus.id_RtValid && bus.id_Rt == bus.ex_DstReg);
        return bus.ex_RegWrite && bus.ex_FwdStage == FWD_WB &&
               bus.ex_DstReg != 5'd0 && src_match;
    endfunction

    // Expected outputs for the current inputs and model state.
    task automatic model_eval();
        exp_count = CNT_W'(m_count);
        if (m_halted)
            exp_flags = 5'b11101;
        else if (m_drain_left > 0)
            exp_flags = {3'b111, m_take(), 1'b0};
        else if (m_take())
            exp_flags = 5'b00010;
        else if (bus.id_Halt)
            exp_flags = 5'b01100;
        else if (m_hazard())
            exp_flags = 5'b11100;
        else
            exp_flags = 5'b00000;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_commit();
        if (rst) begin
            m_halted = 1'b0; m_drain_left = 0; m_count = 0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_drain_left > 0) begin
            if (m_take()) m_drain_left = 0;
            else begin
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) m_halted = 1'b1;
            end
        end else if (!m_take()) begin
            if (bus.id_Halt) m_drain_left = DRAIN;
            else if (m_hazard() && m_count < (1 << CNT_W) - 1) m_count = m_count + 1;
        end
    endtask

    // Apply one cycle's inputs (just after a falling edge) and compute expectations.
    task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsv, input logic rtv, input logic hlt,
                       input logic exw, input logic [1:0] fwd, input logic [4:0] dst,
                       input logic br, input logic z, input logic u);
        rst = r;
        bus.id_Rs = rs; bus.id_Rt = rt; bus.id_RsValid = rsv; bus.id_RtValid = rtv;
        bus.id_Halt = hlt; bus.ex_RegWrite = exw; bus.ex_FwdStage = fwd; bus.ex_DstReg = dst;
        bus.mem_Branch = br; bus.mem_Zero = z; bus.mem_Uncond = u;
        #1;
        model_eval();
        got_flags = {bus.injectNop, bus.pc_Stall, bus.ifid_Stall, bus.branchTaken, bus.halted};
    endtask

    // Commit the model and let the DUT take one rising edge.
    task automatic tick();
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, FWD_WB, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        if (got_flags !== 5'b00000 || bus.stall_count !== 4'd0) begin
            fails++;
            $display("FAIL reset: got flags=%b cnt=%0d, want flags=00000 cnt=0", got_flags, bus.stall_count);
        end
        checks++;
        tick();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 6; i++) begin
            logic [4:0] r;
            logic [4:0] o;
            logic use_rt;
            r = 5'($urandom_range(1, 31));
            o = r ^ 5'd1;
            if (o == 5'd0) o = 5'd2;
            use_rt = 1'($urandom_range(0, 1));
            // Producer load in EXE, consumer in ID
            cyc(1'b0, use_rt ? o : r, use_rt ? r : o, 1'b1, 1'b1, 1'b0,
                1'b1, FWD_WB, r, 1'b0, 1'b0, 1'b0);
            if (got_flags !== exp_flags || bus.stall_count !== exp_count) begin
                fails++;
                $display("FAIL load_use: got flags=%b cnt=%0d, want flags=%b cnt=%0d", got_flags, bus.stall_count, exp_flags, exp_count);
            end
            checks++;
            tick();
            // Bubble now in EXE, load moved to MEM: no second stall
            cyc(1'b0, use_rt ? o : r, use_rt ? r : o, 1'b1, 1'b1, 1'b0,
                1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            if (got_flags !== exp_flags || bus.stall_count !== exp_count) begin
                fails++;
                $display("FAIL load_use_release: got flags=%b cnt=%0d, want flags=%b cnt=%0d", got_flags, bus.stall_count, exp_flags, exp_count);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_no_hazard();
        for (int k = 0; k < 4; k++) begin
            logic [4:0] r;
            r = 5'($urandom_range(1, 31));
            case (k)
                0: cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, FWD_WB, 5'd0, 1'b0, 1'b0, 1'b0);
                1: cyc(1'b0, 5'd0, r, 1'b1, 1'b0, 1'b0, 1'b1, FWD_WB, r, 1'b0, 1'b0, 1'b0);
                2: cyc(1'b0, r, r, 1'b1, 1'b1, 1'b0, 1'b1, FWD_MEM, r, 1'b0, 1'b0, 1'b0);
                default: cyc(1'b0, r, r, 1'b1, 1'b1, 1'b0, 1'b0, FWD_WB, r, 1'b1, 1'b0, 1'b0);
            endcase
            if (got_flags !== exp_flags || bus.stall_count !== exp_count) begin
                fails++;
                $display("FAIL no_hazard[%0d]: got flags=%b cnt=%0d, want flags=%b cnt=%0d", k, got_flags, bus.stall_count, exp_flags, exp_count);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_branch_priority();
        for (int k = 0; k < 4; k++) begin
            logic [4:0] r;
            r = 5'($urandom_range(1, 31));
            // k=0 beq taken, 1 jump, 2 taken with halt, 3 branch not taken -> stall
            cyc(1'b0, r, 5'd0, 1'b1, 1'b0, (k == 2), 1'b1, FWD_WB, r,
                1'b1, (k != 1 && k != 3), (k == 1));
            if (got_flags !== exp_flags || bus.stall_count !== exp_count) begin
                fails++;
                $display("FAIL branch_priority[%0d]: got flags=%b cnt=%0d, want flags=%b cnt=%0d", k, got_flags, bus.stall_count, exp_flags, exp_count);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_halt_drain();
        cyc(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, FWD_WB, 5'd9, 1'b0, 1'b0, 1'b0);
        if (got_flags !== exp_flags) begin
            fails++;
            $display("FAIL halt_decode: got flags=%b, want flags=%b", got_flags, exp_flags);
        end
        checks++;
        tick();
        for (int i = 0; i < DRAIN + 12; i++) begin
            // Inputs random, but no branch during drain; anything goes once halted
            cyc(1'b0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 2'($urandom), 5'($urandom),
                (i >= DRAIN) ? 1'($urandom) : 1'b0, 1'($urandom), 1'($urandom));
            if (got_flags !== exp_flags || bus.stall_count !== exp_count) begin
                fails++;
                $display("FAIL halt_drain[%0d]: got flags=%b cnt=%0d, want flags=%b cnt=%0d", i, got_flags, bus.stall_count, exp_flags, exp_count);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_drain_branch();
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            // First drain cycle quiet, second sees an older jump, then normal run
            cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0,
                (i == 1), 1'b0, (i == 1));
            if (got_flags !== exp_flags || bus.halted !== 1'b0) begin
                fails++;
                $display("FAIL drain_branch[%0d]: got flags=%b, want flags=%b", i, got_flags, exp_flags);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_saturation_and_rst();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, FWD_WB, 5'd5, 1'b0, 1'b0, 1'b0);
            tick();
            cyc(1'b0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            if (bus.stall_count !== exp_count) begin
                fails++;
                $display("FAIL saturation[%0d]: got cnt=%0d, want cnt=%0d", i, bus.stall_count, exp_count);
            end
            checks++;
            tick();
        end
        // Halt, one drain cycle, then reset in the middle of draining
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        if (got_flags !== exp_flags || bus.stall_count !== exp_count) begin
            fails++;
            $display("FAIL rst_mid_drain: got flags=%b cnt=%0d, want flags=%b cnt=%0d", got_flags, bus.stall_count, exp_flags, exp_count);
        end
        checks++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 79) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), ($urandom_range(0, 24) == 0),
                1'($urandom), 2'($urandom), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom));
            if (got_flags !== exp_flags || bus.stall_count !== exp_count) begin
                fails++;
                $display("FAIL random[%0d]: got flags=%b cnt=%0d, want flags=%b cnt=%0d", i, got_flags, bus.stall_count, exp_flags, exp_count);
            end
            checks++;
            tick();
        end
    endtask

    initial begin
        bus.id_Rs = 5'd0; bus.id_Rt = 5'd0; bus.id_RsValid = 1'b0; bus.id_RtValid = 1'b0;
        bus.id_Halt = 1'b0; bus.ex_RegWrite = 1'b0; bus.ex_FwdStage = 2'd0; bus.ex_DstReg = 5'd0;
        bus.mem_Branch = 1'b0; bus.mem_Zero = 1'b0; bus.mem_Uncond = 1'b0;
        m_halted = 1'b0; m_drain_left = 0; m_count = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_priority();
        test_halt_drain();
        test_drain_branch();
        test_saturation_and_rst();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
